multi_read_latency_memory: RTL and testbench

//   Parametrised 1-write / NUM_RD-read synchronous memory with fixed, configurable read latency.

---
 rtl/multi_read_latency_memory.sv | 119 +++++++++++
 tb/tb_multi_read_latency_memory.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_read_latency_memory.sv
// rtl/multi_read_latency_memory.sv - 1-write / NUM_RD-read memory with fixed read latency
//
// Purpose:
//   One write port with byte enables.
//   NUM_RD independent read ports, each with its own shift pipeline.
//   Every read port has a fixed latency of DATA_LAT cycles.
//   The storage array is never reset. Only the valid pipelines are cleared by rst.
//
// Optional feature:
//   MRLM_FWD_EN - when defined, a read and a write to the same address at the same
//   edge return the merged word (new bytes where w_be is set, old bytes elsewhere).
//   When undefined, such a read returns the old, pre-write word.
//
// Ports:
//   clk       clock; all logic runs on posedge
//   rst       synchronous, active-high reset of the read-valid pipelines
//   r_addr    read addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   r_avalid  per-port read request
//   r_dvalid  per-port read data valid
//   r_data    read data; port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   w_addr    write address
//   w_data    write data
//   w_be      byte enables; bit b covers w_data[8*b +: 8]
//   w_valid   write strobe

module multi_read_latency_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RD     = 2,
    parameter int DATA_LAT   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr,
    input  logic [NUM_RD-1:0]              r_avalid,
    output logic [NUM_RD-1:0]              r_dvalid,
    output logic [NUM_RD*DATA_WIDTH-1:0]   r_data,
    input  logic [ADDR_WIDTH-1:0]          w_addr,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic [DATA_WIDTH/8-1:0]        w_be,
    input  logic                           w_valid
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("multi_read_latency_memory: DATA_WIDTH must be a multiple of 8");
    end
    if (DATA_LAT < 1) begin : g_bad_data_lat
        $error("multi_read_latency_memory: DATA_LAT must be at least 1");
    end
    if (NUM_RD < 1) begin : g_bad_num_rd
        $error("multi_read_latency_memory: NUM_RD must be at least 1");
    end

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Writes are deliberately independent of rst: the array holds data across reset.
    always_ff @(posedge clk) begin
        if (w_valid) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (w_be[b]) begin
                    mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] rd_word;
        logic [DATA_LAT-1:0]   vld;
        logic [DATA_WIDTH-1:0] dat [0:DATA_LAT-1];

        assign addr = r_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Word captured into stage 0. The array read sees the pre-write contents
        // at a colliding edge; forwarding overlays the bytes being written.
        always_comb begin
            rd_word = mem[addr];
`ifdef MRLM_FWD_EN
            if (w_valid && (w_addr == addr)) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (w_be[b]) begin
                        rd_word[8*b +: 8] = w_data[8*b +: 8];
                    end
                end
            end
`endif
        end

        // Valid pipeline: cleared by rst so that in-flight requests are dropped
        // and requests presented while rst is high never enter.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= '0;
            end else begin
                vld[0] <= r_avalid[p];
                for (int s = 1; s < DATA_LAT; s++) begin
                    vld[s] <= vld[s-1];
                end
            end
        end

        // Data pipeline: not reset. Stage 0 loads every cycle; the value only
        // matters when the matching valid bit is set.
        always_ff @(posedge clk) begin
            dat[0] <= rd_word;
            for (int s = 1; s < DATA_LAT; s++) begin
                dat[s] <= dat[s-1];
            end
        end

        assign r_dvalid[p]                       = vld[DATA_LAT-1];
        assign r_data[p*DATA_WIDTH +: DATA_WIDTH] = dat[DATA_LAT-1];
    end

endmodule

// File: tb/tb_multi_read_latency_memory.sv
// tb/tb_multi_read_latency_memory.sv - self-checking bench for multi_read_latency_memory

module tb_multi_read_latency_memory;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NR   = 2;
    localparam int DL   = 2;
    localparam int BW   = DW / 8;
    localparam int HMAX = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] r_addr;
    logic [NR-1:0]    r_avalid;
    logic [NR-1:0]    r_dvalid;
    logic [NR*DW-1:0] r_data;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;
    logic [BW-1:0]    w_be;
    logic             w_valid;

    int errors = 0;
    int checks = 0;

    multi_read_latency_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_RD    (NR),
        .DATA_LAT  (DL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .r_addr  (r_addr),
        .r_avalid(r_avalid),
        .r_dvalid(r_dvalid),
        .r_data  (r_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .w_be    (w_be),
        .w_valid (w_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Per edge the model records whether each port's request was accepted, the
    // word it must return, and whether rst was high. A request accepted at edge r
    // is due after edge r+DL-1 unless rst was seen at any edge in (r, r+DL-1].
    logic [DW-1:0] mmem [0:(1<<AW)-1];
    bit            rst_h [0:HMAX-1];
    bit            ok_h  [0:NR-1][0:HMAX-1];
    logic [DW-1:0] dat_h [0:NR-1][0:HMAX-1];
    int            ec = 0;

    always @(posedge clk) begin
        if (ec < HMAX) begin
            rst_h[ec] = rst;
            for (int p = 0; p < NR; p++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] w;
                a = r_addr[p*AW +: AW];
                w = mmem[a];
`ifdef MRLM_FWD_EN
                if (w_valid && w_addr == a)
                    for (int b = 0; b < BW; b++)
                        if (w_be[b]) w[8*b +: 8] = w_data[8*b +: 8];
`endif
                ok_h[p][ec]  = r_avalid[p] && !rst;
                dat_h[p][ec] = w;
            end
            if (w_valid)
                for (int b = 0; b < BW; b++)
                    if (w_be[b]) mmem[w_addr][8*b +: 8] = w_data[8*b +: 8];
            ec++;
        end
    end

    always @(negedge clk) begin
        if (ec >= 1 && ec <= HMAX) begin
            int e;
            e = ec - 1;
            for (int p = 0; p < NR; p++) begin
                int  r;
                bit  exp_v;
                r = e - (DL - 1);
                exp_v = 1'b0;
                if (r >= 0 && ok_h[p][r]) begin
                    exp_v = 1'b1;
                    for (int k = r + 1; k <= e; k++)
                        if (rst_h[k]) exp_v = 1'b0;
                end
                check($sformatf("model_dvalid[%0d]", p), {31'd0, r_dvalid[p]}, {31'd0, exp_v});
                if (exp_v && !$isunknown(dat_h[p][r]))
                    check($sformatf("model_data[%0d]", p), r_data[p*DW +: DW], dat_h[p][r]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        r_avalid = '0;
        w_valid  = 1'b0;
        w_be     = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        w_addr  = a;
        w_data  = d;
        w_be    = be;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        w_be    = '0;
    endtask

    // Issue one read on port p and check it lands exactly DL edges later.
    task automatic read1(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        r_addr[p*AW +: AW] = a;
        r_avalid[p]        = 1'b1;
        tick();
        r_avalid[p] = 1'b0;
        for (int k = 0; k < DL - 1; k++) begin
            check({name, "_early"}, {31'd0, r_dvalid[p]}, 32'd0);
            tick();
        end
        check({name, "_dvalid"}, {31'd0, r_dvalid[p]}, 32'd1);
        check({name, "_data"}, r_data[p*DW +: DW], exp);
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        int pulses0, pulses1;
        r_addr   = '0;
        w_addr   = '0;
        w_data   = '0;
        w_be     = '0;
        w_valid  = 1'b0;

        // 1: reset held with requests asserted
        rst      = 1'b1;
        r_avalid = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_dvalid", {30'd0, r_dvalid}, 32'd0);
        end
        rst      = 1'b0;
        r_avalid = '0;
        for (int i = 0; i < DL; i++) begin
            tick();
            check("rst_release_dvalid", {30'd0, r_dvalid}, 32'd0);
        end

        // 2: basic write then read
        do_write(4'd3, 32'hDEADBEEF, 4'hF);
        read1(0, 4'd3, 32'hDEADBEEF, "basic");

        // 3: byte enables
        do_write(4'd5, 32'h11223344, 4'hF);
        do_write(4'd5, 32'hAABBCCDD, 4'b0101);
        read1(1, 4'd5, 32'h11BB33DD, "byte_en");

        // 4: same-edge read/write collision
        do_write(4'd7, 32'h00000000, 4'hF);
        w_addr      = 4'd7;
        w_data      = 32'h12345678;
        w_be        = 4'hF;
        w_valid     = 1'b1;
        r_addr[0 +: AW] = 4'd7;
        r_avalid[0] = 1'b1;
        tick();
        idle();
        for (int k = 0; k < DL - 1; k++) tick();
        check("collide_dvalid", {31'd0, r_dvalid[0]}, 32'd1);
`ifdef MRLM_FWD_EN
        check("collide_data", r_data[0 +: DW], 32'h12345678);
`else
        check("collide_data", r_data[0 +: DW], 32'h00000000);
`endif
        read1(0, 4'd7, 32'h12345678, "after_collide");

        // 5: fill, then stream both ports back-to-back in opposite orders
        for (int a = 0; a < 16; a++) do_write(a[AW-1:0], a * 32'h01010101, 4'hF);
        pulses0 = 0;
        pulses1 = 0;
        for (int i = 0; i < 16 + DL - 1; i++) begin
            if (i < 16) begin
                r_addr[0 +: AW]  = i[AW-1:0];
                r_addr[AW +: AW] = 4'(15 - i);
                r_avalid         = 2'b11;
            end else begin
                r_avalid = '0;
            end
            tick();
            if (r_dvalid[0]) pulses0++;
            if (r_dvalid[1]) pulses1++;
            if (i >= DL - 1) begin
                check("stream_dvalid", {30'd0, r_dvalid}, 32'd3);
                check("stream_data0", r_data[0 +: DW], (i - (DL - 1)) * 32'h01010101);
                check("stream_data1", r_data[DW +: DW], (15 - (i - (DL - 1))) * 32'h01010101);
            end
        end
        idle();
        check("stream_pulses0", pulses0, 32'd16);
        check("stream_pulses1", pulses1, 32'd16);

        // 6: reset mid-flight - one read in flight when rst is sampled, one read during rst
        r_addr[0 +: AW] = 4'd3;
        r_avalid[0]     = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        r_avalid = '0;
        check("midrst_dvalid_a", {30'd0, r_dvalid}, 32'd0);
        tick();
        check("midrst_dvalid_b", {30'd0, r_dvalid}, 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_dvalid_c", {30'd0, r_dvalid}, 32'd0);
        read1(1, 4'd3, 32'h03030303, "post_rst");
        read1(0, 4'd9, 32'h09090909, "post_rst0");

        // random traffic, memory fully written so every read is defined
        for (int i = 0; i < 500; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            r_avalid = NR'($urandom);
            r_addr   = (NR*AW)'($urandom);
            w_valid  = $urandom_range(0, 1) == 1;
            w_addr   = ($urandom_range(0, 3) == 0) ? r_addr[0 +: AW] : AW'($urandom);
            w_data   = $urandom;
            w_be     = BW'($urandom);
            tick();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < DL + 1; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
